// File: rtl/sum_seg7_display_pkg.sv
// Shared constants, segment table and converter state type for the
// adder-result 7-segment display.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/sum_seg7_display_if.sv
// Bundle of the adder result inputs and the display/observability outputs.
// There is no handshake: sum/cout are level inputs, all outputs are registered levels.
interface sum_seg7_display_if #(parameter int N = 8);
  import seg7_pkg::*;

  logic [N-1:0] sum;
  logic         cout;
  logic [7:0]   an;
  logic [6:0]   seg;
  logic         dp;
  logic [15:0]  bcd;
  logic         busy;
  conv_state_t  state;

  modport master (output sum, cout, input an, seg, dp, bcd, busy, state);
  modport slave  (input sum, cout, output an, seg, dp, bcd, busy, state);

endinterface

// File: rtl/sum_seg7_display_bin2bcd.sv
// Sequential double-dabble converter: starts a conversion whenever the input
// differs from the last converted value, publishes result and value together.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         busy,
  output logic [W-1:0] last,
  output conv_state_t  state
);

  conv_state_t  st;
  logic [W-1:0] sh;
  logic [W-1:0] lat;
  logic [W-1:0] last_r;
  logic [15:0]  scratch;
  logic [15:0]  bcd_r;
  logic [3:0]   iter;
  logic [15:0]  adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      else                           adj[4*i +: 4] = scratch[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= CONV_IDLE;
      sh      <= '0;
      lat     <= '0;
      last_r  <= '0;
      scratch <= '0;
      bcd_r   <= '0;
      iter    <= '0;
    end else begin
      case (st)
        CONV_IDLE: begin
          if (bin != last_r) begin
            sh      <= bin;
            lat     <= bin;
            scratch <= '0;
            iter    <= 4'(W);
            st      <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          {scratch, sh} <= {adj, sh} << 1;
          iter          <= iter - 4'd1;
          if (iter == 4'd1) st <= CONV_DONE;
        end
        CONV_DONE: begin
          // Result and its source value move together so bcd and hex never disagree.
          bcd_r  <= scratch;
          last_r <= lat;
          st     <= CONV_IDLE;
        end
        default: st <= CONV_IDLE;
      endcase
    end
  end

  assign bcd   = bcd_r;
  assign last  = last_r;
  assign busy  = (st != CONV_IDLE);
  assign state = st;

endmodule

// File: rtl/sum_seg7_display.sv
// Shows {cout,sum} on the 8-digit display: decimal on digits 3..0, hex on 7..4,
// with a two-stage input synchronizer and a time-multiplexed digit scanner.
module sum_seg7_display
  import seg7_pkg::*;
#(
  parameter int N           = 8,
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_seg7_display_if.slave  io
);

  localparam int W         = N + 1;
  localparam int HEX_SHOWN = (W + 3) / 4;
  localparam int CW        = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;

  if (N < 1 || N > 12) begin : g_bad_n
    $error("sum_seg7_display: N must be in 1..12");
  end
  if (SCAN_CYCLES < 2) begin : g_bad_scan
    $error("sum_seg7_display: SCAN_CYCLES must be >= 2");
  end

  logic [W-1:0]  v_s1;
  logic [W-1:0]  v_q;
  logic [W-1:0]  v_last;
  logic [15:0]   bcd_val;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic          show;
  logic [3:0]    dec_show;
  logic [15:0]   hex_val;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;

  // sum comes from switches, so it is resynchronised before anything uses it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_s1 <= '0;
      v_q  <= '0;
    end else begin
      v_s1 <= {io.cout, io.sum};
      v_q  <= v_s1;
    end
  end

  bin2bcd_seq #(.W(W)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (v_q),
    .bcd   (bcd_val),
    .busy  (io.busy),
    .last  (v_last),
    .state (io.state)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_CYCLES - 1)) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A decimal digit is shown when it or any more significant digit is nonzero.
  assign dec_show[3] = |bcd_val[15:12];
  assign dec_show[2] = dec_show[3] | (|bcd_val[11:8]);
  assign dec_show[1] = dec_show[2] | (|bcd_val[7:4]);
  assign dec_show[0] = 1'b1;
  assign hex_val     = 16'(v_last);

  always_comb begin
    nib  = 4'h0;
    show = 1'b0;
    if (!idx[2]) begin
      nib  = bcd_val[{idx[1:0], 2'b00} +: 4];
      show = dec_show[idx[1:0]];
    end else begin
      nib  = hex_val[{idx[1:0], 2'b00} +: 4];
      show = (int'(idx[1:0]) < HEX_SHOWN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
    end else if (show) begin
      an_r  <= ~(8'h01 << idx);
      seg_r <= hex_to_seg(nib);
    end else begin
      an_r  <= 8'hFF;
      seg_r <= SEG_BLANK;
    end
  end

  assign io.an  = an_r;
  assign io.seg = seg_r;
  assign io.dp  = 1'b1;
  assign io.bcd = bcd_val;

endmodule
